// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD command codes, RGB565 colours, blitter state type and command-word helper
package lcd_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_FETCH, S_PIXEL, S_DONE} state_t;
  function automatic logic [8:0] cmd_word(input logic [3:0] k, input logic [15:0] xs, xe, ys, ye);
    return k == 4'd0 ? {1'b0, CMD_CASET} :
           k == 4'd1 ? {1'b1, xs[15:8]} :
           k == 4'd2 ? {1'b1, xs[7:0]} :
           k == 4'd3 ? {1'b1, xe[15:8]} :
           k == 4'd4 ? {1'b1, xe[7:0]} :
           k == 4'd5 ? {1'b0, CMD_PASET} :
           k == 4'd6 ? {1'b1, ys[15:8]} :
           k == 4'd7 ? {1'b1, ys[7:0]} :
           k == 4'd8 ? {1'b1, ye[15:8]} :
           k == 4'd9 ? {1'b1, ye[7:0]} : {1'b0, CMD_RAMWR};
  endfunction
endpackage

// File: rtl/lcd_bmp_row_shift.sv
// lcd_bmp_row_shift: bitmap row register, parallel load and right shift
//   i_load loads i_d, i_shift_en shifts right by one; o_bit0 is the current pixel, o_bit1 the next one
module lcd_bmp_row_shift #(
  parameter int ROW_BITS = 240
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                i_load,
  input  logic                i_shift_en,
  input  logic [ROW_BITS-1:0] i_d,
  output logic                o_bit0,
  output logic                o_bit1
);
  logic [ROW_BITS-1:0] r_q;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
    else if (i_shift_en) r_q <= {1'b0, r_q[ROW_BITS-1:1]};
  end
  assign o_bit0 = r_q[0];
  assign o_bit1 = r_q[1];
endmodule

// File: rtl/lcd_show_bitmap.sv
// lcd_show_bitmap: 1-bpp bitmap blitter emitting window commands and RGB565 pixel bytes
//   start/x0/y0/w/h/fg_color/bg_color/rom_base: draw request, latched on accepted start
//   rom_addr/rom_q: row-per-word bitmap ROM port, ROM_LAT cycles latency
//   wr_data/wr_en/wr_done: 9-bit command/data word stream to the LCD write engine
//   busy/done: draw in progress / one-cycle completion pulse
//   LCD_BMP_INVERT_EN: adds input invert, swapping fg/bg for the whole draw
module lcd_show_bitmap
  import lcd_pkg::*;
#(
  parameter int ROW_BITS = 240,
  parameter int ADDR_W   = 9,
  parameter int COORD_W  = 9,
  parameter int ROM_LAT  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  input  logic [COORD_W-1:0]  w,
  input  logic [COORD_W-1:0]  h,
  input  logic [15:0]         fg_color,
  input  logic [15:0]         bg_color,
  input  logic [ADDR_W-1:0]   rom_base,
`ifdef LCD_BMP_INVERT_EN
  input  logic                invert,
`endif
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [ROW_BITS-1:0] rom_q,
  output logic [8:0]          wr_data,
  output logic                wr_en,
  input  logic                wr_done,
  output logic                busy,
  output logic                done
);
  localparam int LAT_W = $clog2(ROM_LAT + 1) + 1;
  state_t              r_state;
  logic [COORD_W-1:0]  r_x0, r_y0, r_w, r_h, r_row, r_col;
  logic [15:0]         r_fg, r_bg;
  logic [ADDR_W-1:0]   r_base, r_rom_addr;
  logic [3:0]          r_idx;
  logic                r_byte, r_wr_en, r_busy, r_done;
  logic [8:0]          r_wr_data;
  logic [LAT_W-1:0]    r_lat;
  logic                w_ack, w_load, w_shift, w_bit0, w_bit1, w_inv;
  logic [COORD_W-1:0]  w_xe, w_ye;
  logic [15:0]         w_col0, w_col1, w_colq;
`ifdef LCD_BMP_INVERT_EN
  logic r_inv;
  assign w_inv = r_inv;
`else
  assign w_inv = 1'b0;
`endif
  assign w_ack   = wr_done & r_wr_en;
  assign w_load  = (r_state == S_FETCH) && (r_lat == LAT_W'(ROM_LAT));
  assign w_shift = (r_state == S_PIXEL) && w_ack && r_byte;
  assign w_xe    = r_x0 + r_w - COORD_W'(1);
  assign w_ye    = r_y0 + r_h - COORD_W'(1);
  // rom_q[0] feeds the first high byte because the shift register loads on the same edge
  assign w_colq  = (rom_q[0] ^ w_inv) ? r_fg : r_bg;
  assign w_col0  = (w_bit0 ^ w_inv) ? r_fg : r_bg;
  assign w_col1  = (w_bit1 ^ w_inv) ? r_fg : r_bg;
  lcd_bmp_row_shift #(.ROW_BITS(ROW_BITS)) u_shift (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_load(w_load), .i_shift_en(w_shift),
    .i_d(rom_q), .o_bit0(w_bit0), .o_bit1(w_bit1)
  );
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_x0 <= x0; r_y0 <= y0; r_w <= w; r_h <= h;
          r_fg <= fg_color; r_bg <= bg_color; r_base <= rom_base;
`ifdef LCD_BMP_INVERT_EN
          r_inv <= invert;
`endif
          r_row <= '0; r_col <= '0; r_idx <= '0; r_byte <= 1'b0;
          r_busy <= 1'b1;
          if (w == '0 || h == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_CMD;
            r_wr_en   <= 1'b1;
            r_wr_data <= {1'b0, CMD_CASET};
          end
        end
        S_CMD: if (w_ack) begin
          if (r_idx == 4'd10) begin
            r_state    <= S_FETCH;
            r_wr_en    <= 1'b0;
            r_rom_addr <= r_base + ADDR_W'(r_row);
            r_lat      <= '0;
          end else begin
            r_idx     <= r_idx + 4'd1;
            r_wr_data <= cmd_word(r_idx + 4'd1, 16'(r_x0), 16'(w_xe), 16'(r_y0), 16'(w_ye));
          end
        end
        S_FETCH: if (w_load) begin
          r_state   <= S_PIXEL;
          r_wr_en   <= 1'b1;
          r_wr_data <= {1'b1, w_colq[15:8]};
          r_byte    <= 1'b0;
          r_col     <= '0;
        end else r_lat <= r_lat + LAT_W'(1);
        S_PIXEL: if (w_ack) begin
          if (!r_byte) begin
            r_byte    <= 1'b1;
            r_wr_data <= {1'b1, w_col0[7:0]};
          end else if (r_col == r_w - COORD_W'(1)) begin
            r_wr_en <= 1'b0;
            if (r_row == r_h - COORD_W'(1)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_row      <= r_row + COORD_W'(1);
              r_rom_addr <= r_base + ADDR_W'(r_row + COORD_W'(1));
              r_lat      <= '0;
            end
          end else begin
            r_col     <= r_col + COORD_W'(1);
            r_byte    <= 1'b0;
            r_wr_data <= {1'b1, w_col1[15:8]};
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign rom_addr = r_rom_addr;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule
